// File: rtl/physics_pkg.sv
`default_nettype none
// ============================================================================
// physics_pkg
// Shared types and constants for the physics engine sprite scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package physics_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } sched_state_t;

    // 60 Hz frame period at a 162 MHz clock
    localparam int unsigned FRAME_CYCLES_60HZ     = 2_700_000;
    localparam int unsigned SETTLE_CYCLES_DEFAULT = 65536;

endpackage
`default_nettype wire

// File: rtl/physics_scheduler_if.sv
`default_nettype none
// ============================================================================
// physics_scheduler_if
// Control bundle between the sprite scheduler and the calc/result datapath.
// master: scheduler side. slave: engine datapath side.
// Revision: 1.0 - initial release
// ============================================================================
interface physics_scheduler_if #(
    parameter int unsigned IDX_W = 4
);
    logic             data_ready;
    logic [IDX_W-1:0] calc_index;
    logic             calc_capture;
    logic             commit;
    logic             load;
    logic             running;
    logic [15:0]      frame_count;
    logic             frame_overrun;

    modport master (
        input  data_ready,
        output calc_index, calc_capture, commit, load, running,
               frame_count, frame_overrun
    );

    modport slave (
        output data_ready,
        input  calc_index, calc_capture, commit, load, running,
               frame_count, frame_overrun
    );
endinterface
`default_nettype wire

// File: rtl/sched_counter.sv
`default_nettype none
// ============================================================================
// sched_counter
// Terminal-count counter 0..MAX with synchronous clear and enable. The
// terminal flag is a look-ahead: high when the count will equal MAX after the
// next edge, so the parent can register strobes aligned with the terminal
// cycle.
// Revision: 1.0 - initial release
// ============================================================================
module sched_counter #(
    parameter int unsigned MAX = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_term_next
);
    localparam int unsigned      c_width = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [c_width-1:0] c_max = c_width'(MAX);

    logic [c_width-1:0] r_count;
    logic [c_width-1:0] w_count_next;

    // Next count: clear wins over enable; wraps to 0 after MAX
    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en) begin
            w_count_next = (r_count == c_max) ? '0 : r_count + c_width'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_term_next = (w_count_next == c_max);

endmodule
`default_nettype wire

// File: rtl/physics_scheduler.sv
`default_nettype none
// ============================================================================
// physics_scheduler
// Sequences the shared per-sprite calc datapath: steps calc_index through the
// sprites with a settle window each, strobes capture into the shadow buffer,
// commits the shadow buffer once per frame and sequences the init-data load.
// All outputs are registered.
// Build option: SCHED_OVERRUN_EN enables the sticky frame_overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
module physics_scheduler
    import physics_pkg::*;
#(
    parameter int unsigned SPRITES        = 9,
    parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
    parameter int unsigned FRAME_CYCLES   = FRAME_CYCLES_60HZ,
    parameter int unsigned IDX_W          = $clog2(SPRITES),
    parameter bit          PARAM_CHECK_EN = 1'b1
) (
    input  wire logic                 clk_162,
    input  wire logic                 rst_l,
    physics_scheduler_if.master       sched_bus
);

    // All sprites must fit in one frame, and each settle window needs at
    // least two cycles so the capture strobe is never on the load cycle.
    if (PARAM_CHECK_EN &&
        ((SPRITES * SETTLE_CYCLES >= FRAME_CYCLES) || (SETTLE_CYCLES < 2))) begin : g_param_check
        $error("physics_scheduler: need SPRITES*SETTLE_CYCLES < FRAME_CYCLES and SETTLE_CYCLES >= 2");
    end

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_next;
    logic [15:0]      r_frame_count;
    logic [15:0]      w_fcount_next;
    logic             r_load;
    logic             r_capture;
    logic             r_commit;
    logic             r_running;
    logic             r_overrun;

    logic w_dr;
    logic w_settle_clr, w_settle_en, w_settle_tc;
    logic w_frame_clr,  w_frame_en,  w_frame_tc;
    logic w_commit_next, w_capture_next, w_overrun_next;

    assign w_dr = sched_bus.data_ready;

    sched_counter #(.MAX(SETTLE_CYCLES - 1)) u_settle_cnt (
        .clk         (clk_162),
        .rst_n       (rst_l),
        .i_clr       (w_settle_clr),
        .i_en        (w_settle_en),
        .o_term_next (w_settle_tc)
    );

    sched_counter #(.MAX(FRAME_CYCLES - 1)) u_frame_cnt (
        .clk         (clk_162),
        .rst_n       (rst_l),
        .i_clr       (w_frame_clr),
        .i_en        (w_frame_en),
        .o_term_next (w_frame_tc)
    );

    // Next state, sprite index and counter controls; load overrides all
    always_comb begin
        w_state_next  = r_state;
        w_index_next  = r_index;
        w_fcount_next = r_frame_count;
        w_settle_clr  = 1'b0;
        w_settle_en   = 1'b0;
        w_frame_clr   = 1'b0;
        w_frame_en    = 1'b0;
        if (w_dr) begin
            w_state_next  = SETTLE;
            w_index_next  = '0;
            w_fcount_next = '0;
            w_settle_clr  = 1'b1;
            w_frame_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_settle_clr = 1'b1;
                    w_frame_clr  = 1'b1;
                end
                SETTLE, DONE: begin
                    w_frame_en = 1'b1;
                    if (r_commit) begin
                        // frame boundary: frame counter wraps, restart sprite 0
                        w_fcount_next = r_frame_count + 16'd1;
                        w_state_next  = SETTLE;
                        w_index_next  = '0;
                        w_settle_clr  = 1'b1;
                    end else if (r_state == SETTLE) begin
                        if (r_capture) begin
                            w_settle_clr = 1'b1;
                            if (r_index < IDX_W'(SPRITES - 1)) begin
                                w_index_next = r_index + IDX_W'(1);
                            end else begin
                                w_state_next = DONE;
                                w_index_next = '0;
                            end
                        end else begin
                            w_settle_en = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_index_next = '0;
                    w_settle_clr = 1'b1;
                    w_frame_clr  = 1'b1;
                end
            endcase
        end
    end

    // Strobes for the coming cycle: load > commit > capture
    assign w_commit_next  = w_frame_tc & ~w_dr & (w_state_next != IDLE);
    assign w_capture_next = w_settle_tc & ~w_dr & (w_state_next == SETTLE) & ~w_commit_next;

`ifdef SCHED_OVERRUN_EN
    // Sticky overrun: a commit while sprites are still settling
    always_comb begin
        w_overrun_next = r_overrun;
        if (w_dr) begin
            w_overrun_next = 1'b0;
        end else if (w_commit_next && (w_state_next == SETTLE)) begin
            w_overrun_next = 1'b1;
        end
    end
`else
    assign w_overrun_next = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            r_state       <= IDLE;
            r_index       <= '0;
            r_frame_count <= '0;
            r_load        <= 1'b0;
            r_capture     <= 1'b0;
            r_commit      <= 1'b0;
            r_running     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_index       <= w_index_next;
            r_frame_count <= w_fcount_next;
            r_load        <= w_dr;
            r_capture     <= w_capture_next;
            r_commit      <= w_commit_next;
            r_running     <= (w_state_next != IDLE);
            r_overrun     <= w_overrun_next;
        end
    end

    assign sched_bus.calc_index    = r_index;
    assign sched_bus.calc_capture  = r_capture;
    assign sched_bus.commit        = r_commit;
    assign sched_bus.load          = r_load;
    assign sched_bus.running       = r_running;
    assign sched_bus.frame_count   = r_frame_count;
    assign sched_bus.frame_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_physics_scheduler.sv
`default_nettype none
// ============================================================================
// tb_physics_scheduler
// Self-checking bench: three schedulers (FRAME_CYCLES 20 / 10 / 12, three
// sprites, four-cycle settle) share one data_ready stimulus. A frame-timeline
// reference model predicts every output every cycle; a vector table pins the
// key cycles; random data_ready pulses and bursts follow.
// Revision: 1.0 - initial release
// ============================================================================
module tb_physics_scheduler;

    localparam int SP = 3;
    localparam int ST = 4;
    localparam int NI = 3;
`ifdef SCHED_OVERRUN_EN
    localparam bit OV_ON = 1'b1;
`else
    localparam bit OV_ON = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          dr;
        int          inst;
        logic [22:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic dr = 1'b0;

    always #5 clk = ~clk;

    physics_scheduler_if #(.IDX_W(2)) bus0 ();
    physics_scheduler_if #(.IDX_W(2)) bus1 ();
    physics_scheduler_if #(.IDX_W(2)) bus2 ();

    assign bus0.data_ready = dr;
    assign bus1.data_ready = dr;
    assign bus2.data_ready = dr;

    physics_scheduler #(.SPRITES(SP), .SETTLE_CYCLES(ST), .FRAME_CYCLES(20),
                        .IDX_W(2), .PARAM_CHECK_EN(1'b1))
        u_dut0 (.clk_162(clk), .rst_l(rst_l), .sched_bus(bus0));
    physics_scheduler #(.SPRITES(SP), .SETTLE_CYCLES(ST), .FRAME_CYCLES(10),
                        .IDX_W(2), .PARAM_CHECK_EN(1'b0))
        u_dut1 (.clk_162(clk), .rst_l(rst_l), .sched_bus(bus1));
    physics_scheduler #(.SPRITES(SP), .SETTLE_CYCLES(ST), .FRAME_CYCLES(12),
                        .IDX_W(2), .PARAM_CHECK_EN(1'b0))
        u_dut2 (.clk_162(clk), .rst_l(rst_l), .sched_bus(bus2));

    // {load, capture, commit, running, overrun, index[1:0], frame_count[15:0]}
    logic [22:0] act [NI];
    assign act[0] = {bus0.load, bus0.calc_capture, bus0.commit, bus0.running,
                     bus0.frame_overrun, bus0.calc_index, bus0.frame_count};
    assign act[1] = {bus1.load, bus1.calc_capture, bus1.commit, bus1.running,
                     bus1.frame_overrun, bus1.calc_index, bus1.frame_count};
    assign act[2] = {bus2.load, bus2.calc_capture, bus2.commit, bus2.running,
                     bus2.frame_overrun, bus2.calc_index, bus2.frame_count};

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int burst  = 0;

    bit          m_act [NI];
    int          m_fs  [NI];
    int          m_fc  [NI];
    bit          m_ov  [NI];
    logic [22:0] m_exp [NI];

    vec_t tab [$];

    function automatic int fr_of(input int i);
        case (i)
            0:       return 20;
            1:       return 10;
            default: return 12;
        endcase
    endfunction

    function automatic logic [22:0] pk(input bit ld, input bit cp, input bit cm,
                                       input bit run, input bit ov, input int idx,
                                       input int fc);
        logic [1:0]  i2;
        logic [15:0] f16;
        i2  = idx[1:0];
        f16 = fc[15:0];
        return {ld, cp, cm, run, ov, i2, f16};
    endfunction

    task automatic add(input int c, input bit d, input int inst, input logic [22:0] e);
        vec_t v;
        v.cyc  = c;
        v.dr   = d;
        v.inst = inst;
        v.exp  = e;
        tab.push_back(v);
    endtask

    task automatic check(input string nm, input int i, input logic [22:0] got,
                         input logic [22:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%06h expected=%06h (ld,cp,cm,run,ov,idx,fc)",
                     nm, i, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0;
            m_fs[i]  = 0;
            m_fc[i]  = 0;
            m_ov[i]  = 1'b0;
            m_exp[i] = '0;
        end
    endtask

    // Frame timeline model: offset o within the current frame decides everything
    task automatic model_cycle(input int i, input bit d);
        int  f, o, slot;
        bit  cm, cp;
        f = fr_of(i);
        if (d) begin
            m_act[i] = 1'b1;
            m_fs[i]  = cyc;
            m_fc[i]  = 0;
            m_ov[i]  = 1'b0;
        end else if (m_act[i] && (cyc - m_fs[i] == f)) begin
            m_fs[i] = cyc;
            m_fc[i] = (m_fc[i] + 1) % 65536;
        end
        if (!m_act[i]) begin
            m_exp[i] = '0;
        end else begin
            o    = cyc - m_fs[i];
            slot = o / ST;
            cm   = (o == f - 1);
            cp   = ((o % ST) == ST - 1) && (slot < SP) && !cm;
            if (cm && (slot < SP) && OV_ON) m_ov[i] = 1'b1;
            m_exp[i] = pk(d, cp, cm, 1'b1, m_ov[i], (slot < SP) ? slot : 0, m_fc[i]);
        end
    endtask

    // One clock: d is sampled at the coming edge; outputs checked 1 time unit later
    task automatic step(input bit d);
        dr = d;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) model_cycle(i, d);
        #1;
        for (int i = 0; i < NI; i++) check("model", i, act[i], m_exp[i]);
    endtask

    task automatic do_reset();
        dr    = 1'b0;
        rst_l = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) check("reset", i, act[i], '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
        cyc   = 1;
    endtask

    initial begin
        model_reset();

        // idle after reset: nothing moves without data_ready
        do_reset();
        repeat (50) step(1'b0);

        // vector table for the directed frame sequence
        add(5,   0, 0, pk(0,0,0,0,0,0,0));
        add(10,  1, 0, pk(0,0,0,0,0,0,0));
        add(11,  0, 0, pk(1,0,0,1,0,0,0));
        add(12,  0, 0, pk(0,0,0,1,0,0,0));
        add(14,  0, 0, pk(0,1,0,1,0,0,0));
        add(15,  0, 0, pk(0,0,0,1,0,1,0));
        add(18,  0, 0, pk(0,1,0,1,0,1,0));
        add(20,  0, 1, pk(0,0,1,1,OV_ON,2,0));
        add(21,  0, 1, pk(0,0,0,1,OV_ON,0,1));
        add(22,  0, 0, pk(0,1,0,1,0,2,0));
        add(22,  0, 2, pk(0,0,1,1,OV_ON,2,0));
        add(23,  0, 0, pk(0,0,0,1,0,0,0));
        add(23,  0, 2, pk(0,0,0,1,OV_ON,0,1));
        add(30,  0, 0, pk(0,0,1,1,0,0,0));
        add(31,  0, 0, pk(0,0,0,1,0,0,1));
        add(34,  0, 0, pk(0,1,0,1,0,0,1));
        add(50,  0, 0, pk(0,0,1,1,0,0,1));
        add(70,  0, 0, pk(0,0,1,1,0,0,2));
        add(71,  0, 0, pk(0,0,0,1,0,0,3));
        add(89,  1, 0, pk(0,0,0,1,0,0,3));
        add(90,  0, 0, pk(1,0,0,1,0,0,0));
        add(108, 1, 0, pk(0,0,0,1,0,0,0));
        add(109, 0, 0, pk(1,0,0,1,0,0,0));
        add(128, 1, 0, pk(0,0,1,1,0,0,0));
        add(129, 0, 0, pk(1,0,0,1,0,0,0));
        add(134, 0, 0, pk(0,0,0,1,0,1,0));

        do_reset();
        for (int i = 0; i < tab.size(); i++) begin
            while (cyc < tab[i].cyc) step(1'b0);
            check("vector", tab[i].inst, act[tab[i].inst], tab[i].exp);
            if (tab[i].dr) step(1'b1);
        end

        // asynchronous reset mid-settle of sprite 1, then quiet until data_ready
        do_reset();
        repeat (12) step(1'b0);

        // random data_ready pulses and short held bursts
        for (int k = 0; k < 3000; k++) begin
            bit d;
            if (burst > 0) begin
                d = 1'b1;
                burst--;
            end else if ($urandom_range(0, 99) < 2) begin
                d     = 1'b1;
                burst = int'($urandom_range(0, 2));
            end else begin
                d = 1'b0;
            end
            step(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/physics_scheduler.md
# physics_scheduler

Sequencer for the shared per-sprite calc datapath in the physics engine. Generates the sprite index that steers the two calc instances, a settle window per sprite, a capture strobe into the shadow result buffer, and a frame-rate commit strobe that copies the shadow buffer into the live location/velocity registers. Also sequences the initial-data load. Replaces the free-running counter and sprite-index logic inside the engine top with one explicit state machine.

## Interface

Parameters:
- SPRITES, 9, number of sprites sequenced
- SETTLE_CYCLES, 65536, cycles each sprite index is held before capture (≥2)
- FRAME_CYCLES, 2_700_000, cycles per physics frame (60 Hz at 162 MHz)
- IDX_W, $clog2(SPRITES), sprite index width

Ports:
- clk_162  in  1  sole clock
- rst_l  in  1  asynchronous, active-low reset
- data_ready  in  1  level/pulse; request to load init data and restart
- calc_index  out  IDX_W  sprite index driven to calc datapath
- calc_capture  out  1  one-cycle strobe: write calc results for calc_index into the shadow buffer
- commit  out  1  one-cycle strobe: shadow buffer → live registers
- load  out  1  one-cycle strobe: init data → live registers
- running  out  1  high in every state except IDLE
- frame_count  out  16  completed commits since last load, wraps at 0xFFFF→0
- frame_overrun  out  1  sticky: frame ended before all sprites captured

## Operation

- States: IDLE, SETTLE, DONE. All outputs are registered.
- Reset: state IDLE, all outputs 0, all counters 0.
- IDLE: no strobes; frame counter stopped. data_ready → load.
- Load (any state): when data_ready is sampled high, next cycle load=1, state SETTLE, calc_index=0, settle counter=0, frame counter=0, frame_count=0, frame_overrun=0. Held data_ready re-triggers load every cycle.
- SETTLE: settle counter increments each cycle. When it equals SETTLE_CYCLES-1, calc_capture=1 in that cycle (calc_index unchanged). Next cycle: if calc_index<SPRITES-1, index+1 and counter 0; else state DONE and calc_index=0.
- DONE: idle until the frame boundary.
- Frame counter runs 0..FRAME_CYCLES-1 in SETTLE/DONE. At FRAME_CYCLES-1: commit=1. Next cycle: frame_count+1, frame counter 0, state SETTLE, calc_index 0, settle counter 0.
- Commit from SETTLE (overrun): commit still issued (shadow holds partial results); frame_overrun set.
- Priority on the same cycle: load > commit > capture. A capture coinciding with commit is suppressed and counts as overrun. A data_ready coinciding with a boundary suppresses that commit and frame_count increment.
- Required: SPRITES·SETTLE_CYCLES < FRAME_CYCLES; elaboration-time assertion.

## Timing

- data_ready sampled at edge N → load high cycle N+1; first capture at cycle N+SETTLE_CYCLES.
- Sprite k capture at N + (k+1)·SETTLE_CYCLES.
- First commit at N+FRAME_CYCLES; subsequent commits every FRAME_CYCLES cycles.
- load, commit, calc_capture each exactly one cycle wide; never two in the same cycle.
- Asynchronous reset mid-frame: immediate return to reset values; no strobe on deassertion release.

## Configuration

- SCHED_OVERRUN_EN defined: frame_overrun logic and capture/commit collision detection as above.
- Not defined: frame_overrun tied 0; capture coinciding with commit still suppressed; no other change.

## Structure

- physics_pkg: sched_state_t enum (IDLE, SETTLE, DONE), FRAME_CYCLES_60HZ = 2_700_000, SETTLE_CYCLES_DEFAULT = 65536.
- One sub-module: sched_counter (parameterised terminal-count counter with synchronous clear, enable, terminal flag), instantiated for the settle and frame counters.

## Test plan

Bench params: SPRITES=3, SETTLE_CYCLES=4, FRAME_CYCLES=20.
- Reset then idle 50 cycles → all outputs 0, running=0, no strobes.
- data_ready pulse at edge 10 → load at 11; captures at 14, 18, 22 with index 0,1,2; commit at 30; frame_count=1 at 31.
- Three frames free-running → commits at 30, 50, 70; frame_count=3; frame_overrun=0.
- FRAME_CYCLES=10 (violating the requirement, assertion disabled) → commit at 20 during SETTLE index 2; frame_overrun=1 (0 with macro undefined); index 0 at 21.
- data_ready on the commit cycle of frame 1 → load asserted, commit absent, frame_count=0.
- rst_l low mid-SETTLE index 1 → outputs 0 immediately; after release, no strobes until data_ready.
